// File: rtl/csr_trap_ctrl.sv
// csr_trap_ctrl: trap-entry controller behind the CSR access-check stage.
// Latency: accept -> flush_o next cycle; redirect strobe one cycle after flush_ack_i (minimum 2 cycles from accept).
// Backpressure: csr_exception_ready_o is high only in IDLE; flush_o holds until flush_ack_i.
//
// Ports:
//   clk_i, rst_i                  clock, synchronous active-high reset
//   csr_exception_valid_i/_ready_o request handshake; cause/tval/pc_i are the payload
//   mtvec_i, debug_mode_i         trap vector CSR and debug state, sampled at accept
//   flush_o / flush_ack_i         pipeline flush request/acknowledge
//   trap_valid_o, trap_pc_o       one-cycle redirect strobe and target
//   mepc_o, mcause_o, mtval_o     latched trap CSRs
//   busy_o                        controller is not IDLE
//   trap_cnt_o                    saturating count of non-debug traps (only with CSR_TRAP_CNT_EN)
//
// Optional feature macro: CSR_TRAP_CNT_EN adds the trap_cnt_o counter.

module csr_trap_ctrl #(
  parameter int unsigned          XLEN           = 64,
  parameter logic [XLEN-1:0]      DEBUG_EXC_ADDR = 64'h0000_0000_0000_0808
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            csr_exception_valid_i,
  input  logic [XLEN-1:0] csr_exception_cause_i,
  input  logic [XLEN-1:0] csr_exception_tval_i,
  output logic            csr_exception_ready_o,
  input  logic [XLEN-1:0] pc_i,
  input  logic [XLEN-1:0] mtvec_i,
  input  logic            debug_mode_i,
  output logic            flush_o,
  input  logic            flush_ack_i,
  output logic            trap_valid_o,
  output logic [XLEN-1:0] trap_pc_o,
  output logic [XLEN-1:0] mepc_o,
  output logic [XLEN-1:0] mcause_o,
  output logic [XLEN-1:0] mtval_o,
`ifdef CSR_TRAP_CNT_EN
  output logic [15:0]     trap_cnt_o,
`endif
  output logic            busy_o
);

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_t;

  state_t          state;
  logic            ready_q;
  logic            flush_q;
  logic            trap_valid_q;
  logic            busy_q;
  logic [XLEN-1:0] trap_pc_q;
  logic [XLEN-1:0] target_q;
  logic [XLEN-1:0] mepc_q;
  logic [XLEN-1:0] mcause_q;
  logic [XLEN-1:0] mtval_q;

  logic            accept;
  logic [XLEN-1:0] vec_base;
  logic [XLEN-1:0] vec_off;
  logic [XLEN-1:0] target_next;
  logic            is_vectored;

  assign accept = csr_exception_valid_i & ready_q;

  // Trap target selection. Only mode 1 with an interrupt cause vectors;
  // modes 2 and 3 fall back to direct. The vectored offset is the cause
  // code times four, dropping the interrupt bit; the sum may wrap.
  always_comb begin
    vec_base    = {mtvec_i[XLEN-1:2], 2'b00};
    vec_off     = {csr_exception_cause_i[XLEN-3:0], 2'b00};
    is_vectored = (mtvec_i[1:0] == 2'b01) && csr_exception_cause_i[XLEN-1];
    target_next = vec_base;
    if (debug_mode_i) begin
      target_next = DEBUG_EXC_ADDR;
    end else if (is_vectored) begin
      target_next = vec_base + vec_off;
    end
  end

  // Single FSM register block; every output is registered so the handshake
  // signals come straight from flops.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= ST_IDLE;
      ready_q      <= 1'b1;
      flush_q      <= 1'b0;
      trap_valid_q <= 1'b0;
      busy_q       <= 1'b0;
      trap_pc_q    <= '0;
      target_q     <= '0;
      mepc_q       <= '0;
      mcause_q     <= '0;
      mtval_q      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (accept) begin
            state    <= ST_FLUSH;
            ready_q  <= 1'b0;
            flush_q  <= 1'b1;
            busy_q   <= 1'b1;
            // Target is frozen here so later mtvec/debug changes cannot
            // steer an in-flight trap.
            target_q <= target_next;
            // Debug-mode exceptions leave the machine trap CSRs untouched.
            if (!debug_mode_i) begin
              mepc_q   <= {pc_i[XLEN-1:2], 2'b00};
              mcause_q <= csr_exception_cause_i;
              mtval_q  <= csr_exception_tval_i;
            end
          end
        end
        ST_FLUSH: begin
          if (flush_ack_i) begin
            state        <= ST_REDIRECT;
            flush_q      <= 1'b0;
            trap_valid_q <= 1'b1;
            trap_pc_q    <= target_q;
          end
        end
        ST_REDIRECT: begin
          state        <= ST_IDLE;
          trap_valid_q <= 1'b0;
          trap_pc_q    <= '0;
          busy_q       <= 1'b0;
          ready_q      <= 1'b1;
        end
        default: begin
          state        <= ST_IDLE;
          ready_q      <= 1'b1;
          flush_q      <= 1'b0;
          trap_valid_q <= 1'b0;
          busy_q       <= 1'b0;
          trap_pc_q    <= '0;
        end
      endcase
    end
  end

`ifdef CSR_TRAP_CNT_EN
  logic [15:0] trap_cnt_q;

  // Counts machine-mode trap entries only; sticks at all-ones.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      trap_cnt_q <= '0;
    end else if (accept && !debug_mode_i && (trap_cnt_q != 16'hFFFF)) begin
      trap_cnt_q <= trap_cnt_q + 16'd1;
    end
  end

  assign trap_cnt_o = trap_cnt_q;
`endif

  assign csr_exception_ready_o = ready_q;
  assign flush_o               = flush_q;
  assign trap_valid_o          = trap_valid_q;
  assign trap_pc_o             = trap_pc_q;
  assign mepc_o                = mepc_q;
  assign mcause_o              = mcause_q;
  assign mtval_o               = mtval_q;
  assign busy_o                = busy_q;

endmodule

// File: tb/tb_csr_trap_ctrl.sv
// Testbench for csr_trap_ctrl: directed trap scenarios with a scoreboard of
// expected redirect targets, checked by an independent monitor process.
module tb_csr_trap_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        vld = 1'b0;
  logic [63:0] cause = '0;
  logic [63:0] tval = '0;
  logic [63:0] pc = '0;
  logic [63:0] mtvec = '0;
  logic        dbg = 1'b0;
  logic        ack = 1'b0;
  logic        rdy, flush, tvld, busy;
  logic [63:0] tpc, mepc, mcause, mtval;
`ifdef CSR_TRAP_CNT_EN
  logic [15:0] cnt;
  logic [15:0] e_cnt = '0;
`endif

  int n_chk  = 0;
  int n_fail = 0;

  logic [63:0] exp_q[$];
  logic [63:0] e_mepc = '0, e_mcause = '0, e_mtval = '0;

  csr_trap_ctrl dut (
    .clk_i                 (clk),
    .rst_i                 (rst),
    .csr_exception_valid_i (vld),
    .csr_exception_cause_i (cause),
    .csr_exception_tval_i  (tval),
    .csr_exception_ready_o (rdy),
    .pc_i                  (pc),
    .mtvec_i               (mtvec),
    .debug_mode_i          (dbg),
    .flush_o               (flush),
    .flush_ack_i           (ack),
    .trap_valid_o          (tvld),
    .trap_pc_o             (tpc),
    .mepc_o                (mepc),
    .mcause_o              (mcause),
    .mtval_o               (mtval),
`ifdef CSR_TRAP_CNT_EN
    .trap_cnt_o            (cnt),
`endif
    .busy_o                (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every redirect strobe must match the oldest pending expectation;
  // outside a strobe the target bus must read zero.
  always @(negedge clk) begin
    if (tvld === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_chk++;
        n_fail++;
        $display("FAIL unexpected_redirect: got trap_pc %h expected no strobe at %0t", tpc, $time);
      end else begin
        chk("redirect_pc", tpc, exp_q.pop_front());
      end
    end else begin
      chk("idle_trap_pc", tpc, 64'h0);
    end
  end

  // Drive one request, wait (bounded) for acceptance, return just after the accept edge.
  task automatic send(input logic [63:0] c, input logic [63:0] t, input logic [63:0] p,
                      input logic [63:0] v, input logic d, input bit keep);
    int n;
    @(negedge clk);
    cause = c; tval = t; pc = p; mtvec = v; dbg = d; vld = 1'b1;
    n = 0;
    while (rdy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (rdy !== 1'b1) begin
      n_chk++;
      n_fail++;
      $display("FAIL accept_timeout: got ready %b expected 1 within 20 cycles", rdy);
    end
    @(posedge clk);
    #1;
    if (!keep) vld = 1'b0;
  endtask

  // Walk FLUSH (hold+1 cycles), REDIRECT, then the IDLE cycle after it.
  task automatic run_flush(input int hold);
    for (int i = 0; i <= hold; i++) begin
      @(negedge clk);
      chk("flush_high", {63'h0, flush}, 64'h1);
      chk("flush_ready_low", {63'h0, rdy}, 64'h0);
      chk("flush_busy", {63'h0, busy}, 64'h1);
      chk("flush_no_strobe", {63'h0, tvld}, 64'h0);
      chk("mepc", mepc, e_mepc);
      chk("mcause", mcause, e_mcause);
      chk("mtval", mtval, e_mtval);
      if (i == hold) ack = 1'b1;
    end
    @(negedge clk);
    ack = 1'b0;
    chk("redirect_strobe", {63'h0, tvld}, 64'h1);
    chk("redirect_flush_low", {63'h0, flush}, 64'h0);
    chk("redirect_ready_low", {63'h0, rdy}, 64'h0);
    chk("redirect_mcause", mcause, e_mcause);
    @(negedge clk);
    chk("post_ready", {63'h0, rdy}, 64'h1);
    chk("post_busy", {63'h0, busy}, 64'h0);
    chk("post_strobe", {63'h0, tvld}, 64'h0);
  endtask

  task automatic model_accept(input logic [63:0] c, input logic [63:0] t, input logic [63:0] p, input logic d);
    if (!d) begin
      e_mepc = {p[63:2], 2'b00};
      e_mcause = c;
      e_mtval = t;
`ifdef CSR_TRAP_CNT_EN
      if (e_cnt != 16'hFFFF) e_cnt = e_cnt + 16'd1;
`endif
    end
  endtask

  task automatic trap(input logic [63:0] c, input logic [63:0] t, input logic [63:0] p,
                      input logic [63:0] v, input logic d, input logic [63:0] tgt, input int hold);
    exp_q.push_back(tgt);
    model_accept(c, t, p, d);
    send(c, t, p, v, d, 1'b0);
    run_flush(hold);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200000");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", {63'h0, rdy}, 64'h1);
    chk("rst_flush", {63'h0, flush}, 64'h0);
    chk("rst_busy", {63'h0, busy}, 64'h0);
    chk("rst_strobe", {63'h0, tvld}, 64'h0);
    chk("rst_mepc", mepc, 64'h0);
    chk("rst_mcause", mcause, 64'h0);
    chk("rst_mtval", mtval, 64'h0);
`ifdef CSR_TRAP_CNT_EN
    chk("rst_cnt", {48'h0, cnt}, 64'h0);
`endif

    // flush_ack while idle must be ignored
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    chk("idle_ack_busy", {63'h0, busy}, 64'h0);
    chk("idle_ack_flush", {63'h0, flush}, 64'h0);

    // direct-mode illegal instruction
    trap(64'h2, 64'h7b0, 64'h1006, 64'h8000_0000, 1'b0, 64'h8000_0000, 0);
    chk("direct_mepc", mepc, 64'h1004);
    // vectored interrupt, then same cause with direct mode
    trap(64'h8000_0000_0000_0007, 64'h0, 64'h2000, 64'h8000_0001, 1'b0, 64'h8000_001C, 0);
    trap(64'h8000_0000_0000_0007, 64'h0, 64'h2004, 64'h8000_0000, 1'b0, 64'h8000_0000, 0);
    // mode 3 is direct
    trap(64'h8000_0000_0000_0007, 64'h1, 64'h2008, 64'h8000_0003, 1'b0, 64'h8000_0000, 0);
    // vectored mode but synchronous exception -> base
    trap(64'h5, 64'h2, 64'h200C, 64'h8000_0101, 1'b0, 64'h8000_0100, 1);
    // vectored wrap-around: base ...FFF0 + 4*4 = 0
    trap(64'h8000_0000_0000_0004, 64'h3, 64'h2010, 64'hFFFF_FFFF_FFFF_FFF1, 1'b0, 64'h0, 0);

    // debug mode: CSRs unchanged, target latched despite later input changes
    exp_q.push_back(64'h808);
    model_accept(64'h2, 64'h123, 64'h3000, 1'b1);
    send(64'h2, 64'h123, 64'h3000, 64'h8000_0001, 1'b1, 1'b0);
    dbg = 1'b0;
    mtvec = 64'h0;
    run_flush(1);
    chk("debug_mcause_kept", mcause, 64'h8000_0000_0000_0004);
`ifdef CSR_TRAP_CNT_EN
    chk("debug_cnt", {48'h0, cnt}, {48'h0, e_cnt});
`endif

    // flush backpressure with a second request held pending
    exp_q.push_back(64'h4000_0000);
    model_accept(64'h2, 64'hAA, 64'h5008, 1'b0);
    send(64'h2, 64'hAA, 64'h5008, 64'h4000_0000, 1'b0, 1'b1);
    cause = 64'h3; tval = 64'hBB; pc = 64'h600A;
    run_flush(5);
    exp_q.push_back(64'h4000_0000);
    model_accept(64'h3, 64'hBB, 64'h600A, 1'b0);
    @(posedge clk);
    #1;
    vld = 1'b0;
    run_flush(0);
    chk("second_mepc", mepc, 64'h6008);

    // reset mid-FLUSH discards the trap
    send(64'h2, 64'h9, 64'h7000, 64'h8000_0000, 1'b0, 1'b0);
    @(negedge clk);
    chk("pre_rst_flush", {63'h0, flush}, 64'h1);
    rst = 1'b1;
    ack = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    ack = 1'b0;
    chk("midrst_ready", {63'h0, rdy}, 64'h1);
    chk("midrst_flush", {63'h0, flush}, 64'h0);
    chk("midrst_busy", {63'h0, busy}, 64'h0);
    chk("midrst_strobe", {63'h0, tvld}, 64'h0);
    chk("midrst_mepc", mepc, 64'h0);
    chk("midrst_mcause", mcause, 64'h0);
    chk("midrst_mtval", mtval, 64'h0);
    e_mepc = '0; e_mcause = '0; e_mtval = '0;
`ifdef CSR_TRAP_CNT_EN
    chk("midrst_cnt", {48'h0, cnt}, 64'h0);
    e_cnt = '0;
`endif
    repeat (5) @(negedge clk);

    // recovery after reset
    trap(64'h2, 64'h44, 64'h8003, 64'h8000_0000, 1'b0, 64'h8000_0000, 0);

`ifdef CSR_TRAP_CNT_EN
    @(negedge clk);
    force dut.trap_cnt_q = 16'hFFFE;
    @(negedge clk);
    release dut.trap_cnt_q;
    e_cnt = 16'hFFFE;
    for (int k = 0; k < 3; k++) begin
      trap(64'h2, 64'h0, 64'h9000, 64'h8000_0000, 1'b0, 64'h8000_0000, 0);
    end
    chk("cnt_saturate", {48'h0, cnt}, {48'h0, e_cnt});
    chk("cnt_ffff", {48'h0, cnt}, 64'hFFFF);
`endif

    repeat (3) @(negedge clk);
    chk("scoreboard_empty", 64'(exp_q.size()), 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/csr_trap_ctrl.md
# csr_trap_ctrl

Trap-entry controller directly downstream of the CSR access-check stage. It accepts one exception at a time (cause and tval, e.g. ILLEGAL_INSTR = 2 for an illegal debug-only CSR access), latches mepc/mcause/mtval, and flushes the pipeline through a request/acknowledge handshake. It then issues a one-cycle redirect to the trap vector, or to the debug exception address while in debug mode.

## Interface
Parameters:
- XLEN, 64, datapath width of cause, tval, pc and vector.
- DEBUG_EXC_ADDR, 64'h0000_0000_0000_0808, redirect target for exceptions raised while in debug mode.

Ports:
- clk_i  in  1  clock; all state updates on its rising edge.
- rst_i  in  1  reset, synchronous, active-high.
- csr_exception_valid_i  in  1  exception request from the CSR check stage.
- csr_exception_cause_i  in  XLEN  cause; bit XLEN-1 set means interrupt.
- csr_exception_tval_i  in  XLEN  trap value.
- csr_exception_ready_o  out  1  high only in IDLE.
- pc_i  in  XLEN  PC of the faulting instruction, sampled with the request.
- mtvec_i  in  XLEN  trap vector CSR; [1:0] = mode.
- debug_mode_i  in  1  core is in debug mode.
- flush_o  out  1  pipeline flush request.
- flush_ack_i  in  1  flush complete.
- trap_valid_o  out  1  one-cycle redirect strobe.
- trap_pc_o  out  XLEN  redirect target, valid while trap_valid_o is high.
- mepc_o, mcause_o, mtval_o  out  XLEN each  latched trap CSRs.
- busy_o  out  1  state is not IDLE.

## Operation
- FSM states: IDLE, FLUSH, REDIRECT.
  - IDLE -> FLUSH on accept (csr_exception_valid_i & csr_exception_ready_o).
  - FLUSH -> REDIRECT when flush_ack_i is high.
  - REDIRECT -> IDLE unconditionally.
- On accept with debug_mode_i low:
  - mepc_o <= {pc_i[XLEN-1:2], 2'b00}.
  - mcause_o <= cause; mtval_o <= tval.
  - Target: base = {mtvec_i[XLEN-1:2], 2'b00}.
    - mtvec_i[1:0] == 2'b01 and cause[XLEN-1] == 1: target = base + (cause[XLEN-2:0] << 2), truncated to XLEN (wrap-around allowed).
    - Otherwise: target = base. Mode values 2 and 3 are treated as direct mode.
- On accept with debug_mode_i high: mepc/mcause/mtval unchanged; target = DEBUG_EXC_ADDR.
- Target is latched at accept. mtvec_i and debug_mode_i changes after accept have no effect.
- Requests while not in IDLE are not accepted. Upstream holds valid and payload stable until accepted.
- flush_o = (state == FLUSH). trap_valid_o = (state == REDIRECT). trap_pc_o = latched target, 0 outside REDIRECT.
- flush_ack_i outside FLUSH is ignored.

## Timing
- Reset values:
  - state IDLE; flush_o, trap_valid_o, busy_o = 0.
  - csr_exception_ready_o = 1 in the first cycle after reset.
  - trap_pc_o, mepc_o, mcause_o, mtval_o = 0.
- Accept at edge N:
  - flush_o high in cycle N+1.
  - With flush_ack_i high in cycle N+1: trap_valid_o high in cycle N+2 and ready high again in cycle N+3. Minimum accept-to-redirect latency is 2 cycles.
  - flush_o stays high indefinitely until flush_ack_i.
- mepc_o/mcause_o/mtval_o update at the accept edge and are visible in cycle N+1.
- Back-to-back exceptions: the earliest next accept is the edge ending the cycle N+3 IDLE cycle.
- rst_i asserted in any state: next cycle IDLE with all outputs at reset values. An in-flight trap is discarded and no trap_valid_o pulse is issued.

## Configuration
- CSR_TRAP_CNT_EN defined:
  - Adds output trap_cnt_o [15:0], reset 0.
  - Increments on each accept with debug_mode_i low; saturates at 16'hFFFF.
  - Debug-mode accepts are not counted.
- Undefined: port and counter are absent; all other behaviour is identical.

## Test plan
- Direct-mode illegal CSR: mtvec_i=64'h8000_0000, cause=2, tval=64'h7b0, pc_i=64'h1006, flush_ack_i high in the FLUSH cycle. Expect mepc_o=64'h1004, mcause_o=2, mtval_o=64'h7b0, trap_valid_o pulse at N+2 with trap_pc_o=64'h8000_0000.
- Vectored interrupt: mtvec_i=64'h8000_0001, cause=64'h8000_0000_0000_0007. Expect trap_pc_o=64'h8000_001C. Same cause with mtvec_i=64'h8000_0000: expect 64'h8000_0000.
- Debug mode: debug_mode_i=1 with a cause=2 request. Expect trap_pc_o=64'h808, mepc/mcause/mtval unchanged, trap_cnt_o not incremented.
- Flush backpressure: hold flush_ack_i low 5 cycles. Expect flush_o high 6 cycles, ready low throughout, and a second valid request not accepted until the cycle after REDIRECT.
- Reset mid-FLUSH: assert rst_i. Expect all outputs 0, ready=1, and no trap_valid_o pulse ever for the discarded trap.
- With CSR_TRAP_CNT_EN defined: force the counter to 16'hFFFE, then run 3 non-debug traps. Expect trap_cnt_o=16'hFFFF and holding.
